// File: rtl/dpo_byte_packer.sv
// dpo_byte_packer
// Packs an 8-bit byte stream from the readout logic into 32-bit little-endian
// words and writes them into the DP output FIFO. A partial word is padded and
// flushed at end of event, or after FLUSH_TIMEOUT idle cycles.
//
// Ports:
//   clk_i        clock
//   rstn_i       asynchronous active-low reset
//   byte_dt_i    input byte
//   byte_vld_i   byte valid
//   byte_last_i  last byte of event (only meaningful with byte_vld_i)
//   byte_rdy_o   packer can accept a byte this cycle
//   fifo_dt_o    word to DP FIFO (holding register)
//   fifo_wr_o    DP FIFO write strobe
//   fifo_full_i  DP FIFO full
//   wrd_cnt_o    words written since reset, modulo 2^16
//   flsh_o       pulse when a padded word enters the holding register
//
// state | meaning
// IDLE  | lane 0, no partial word in the accumulator
// FILL  | 1..3 lanes filled, idle timer running
// TMO   | idle timer expired, waiting to move padded word into holding reg
module dpo_byte_packer #(
    parameter int unsigned FLUSH_TIMEOUT = 16,
    parameter logic [7:0]  PAD_BYTE      = 8'h00
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [7:0]  byte_dt_i,
    input  logic        byte_vld_i,
    input  logic        byte_last_i,
    output logic        byte_rdy_o,
    output logic [31:0] fifo_dt_o,
    output logic        fifo_wr_o,
    input  logic        fifo_full_i,
    output logic [15:0] wrd_cnt_o,
    output logic        flsh_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_TMO  = 2'd2
    } state_t;

    // Down-counter reloaded on every accepted byte; expiry when it reads zero
    // on a cycle without an accepted byte gives FLUSH_TIMEOUT idle cycles.
    localparam logic [7:0] TMO_LOAD = 8'(FLUSH_TIMEOUT - 1);

    state_t      state;
    logic [31:0] acc;
    logic [1:0]  lane;
    logic [31:0] hold;
    logic        hold_vld;
    logic [7:0]  tmo_cnt;
    logic [15:0] wrd_cnt;
    logic        flsh;

    logic        accept;
    logic        word_done;
    logic [31:0] byte_word;
    logic [31:0] tmo_word;

    assign fifo_wr_o  = hold_vld & ~fifo_full_i;
    assign byte_rdy_o = (state != ST_TMO) & (~hold_vld | ~fifo_full_i);
    assign fifo_dt_o  = hold;
    assign wrd_cnt_o  = wrd_cnt;
    assign flsh_o     = flsh;

    assign accept    = byte_vld_i & byte_rdy_o;
    assign word_done = byte_last_i | (lane == 2'd3);

    // byte_word: accumulator with the current byte merged and lanes above it
    // padded (no padding on lane 3). tmo_word: lanes from the current lane up
    // are padded since no byte has arrived for them.
    always_comb begin
        byte_word = acc;
        byte_word[{lane, 3'b000} +: 8] = byte_dt_i;
        tmo_word = acc;
        for (int i = 0; i < 4; i++) begin
            if (i > int'(lane)) begin
                byte_word[i*8 +: 8] = PAD_BYTE;
            end
            if (i >= int'(lane)) begin
                tmo_word[i*8 +: 8] = PAD_BYTE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= ST_IDLE;
            acc      <= '0;
            lane     <= '0;
            hold     <= '0;
            hold_vld <= 1'b0;
            tmo_cnt  <= '0;
            wrd_cnt  <= '0;
            flsh     <= 1'b0;
        end else begin
            flsh <= 1'b0;

            if (fifo_wr_o) begin
                hold_vld <= 1'b0;
                wrd_cnt  <= wrd_cnt + 16'd1;
            end

            if (state == ST_TMO) begin
                // Holding register free or draining this cycle: reload it.
                if (!hold_vld || fifo_wr_o) begin
                    hold     <= tmo_word;
                    hold_vld <= 1'b1;
                    flsh     <= 1'b1;
                    acc      <= '0;
                    lane     <= '0;
                    state    <= ST_IDLE;
                end
            end else if (accept) begin
                if (word_done) begin
                    hold     <= byte_word;
                    hold_vld <= 1'b1;
                    flsh     <= (lane != 2'd3);
                    acc      <= '0;
                    lane     <= '0;
                    state    <= ST_IDLE;
                end else begin
                    acc[{lane, 3'b000} +: 8] <= byte_dt_i;
                    lane    <= lane + 2'd1;
                    tmo_cnt <= TMO_LOAD;
                    state   <= ST_FILL;
                end
            end else if (state == ST_FILL) begin
                if (tmo_cnt == 8'd0) begin
                    state <= ST_TMO;
                end else begin
                    tmo_cnt <= tmo_cnt - 8'd1;
                end
            end
        end
    end

endmodule
